// File: rtl/audio_bus_arbiter.sv
// audio_bus_arbiter: round-robin audio bus arbiter with device-ID authorization.
// Optional consecutive-reject lockout is enabled by defining AUDIO_ARB_LOCKOUT_EN.
module audio_bus_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int GRANT_CYCLES = 10,
    parameter int IDX_W        = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] dev_id,
    // per-channel early release; "release" itself is a reserved word
    input  logic [NUM_REQ-1:0]   early_release,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 bus_grant,
    output logic                 bus_busy,
    output logic [7:0]           bus_key,
    output logic [IDX_W-1:0]     granted_idx,
    output logic [NUM_REQ-1:0]   reject,
    output logic [NUM_REQ-1:0]   locked
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_GRANT,
        S_GAP
    } state_t;

    state_t state;
    state_t state_nx;

    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   scan_j;
    logic [IDX_W-1:0]   nxt_idx;
    logic               pick_vld;
    logic [NUM_REQ-1:0] eligible;
    logic [7:0]         id_q;
    logic [7:0]         key_q;
    logic [7:0]         lut_key;
    logic               lut_ok;
    logic [7:0]         timer;
    logic               req_sel;
    logic               rel_sel;
    logic               tenure_end;

    assign eligible   = req & ~locked;
    assign req_sel    = req[granted_idx];
    assign rel_sel    = early_release[granted_idx];
    assign tenure_end = rel_sel || (timer == 8'd1);
    assign nxt_idx    = (int'(granted_idx) == NUM_REQ - 1) ?
                        '0 : granted_idx + 1'b1;

    // Scan downward so the lowest offset from rr_ptr wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan_j   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            scan_j = IDX_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (eligible[scan_j]) begin
                pick_vld = 1'b1;
                pick_idx = scan_j;
            end
        end
    end

    always_comb begin
        lut_ok  = 1'b1;
        lut_key = 8'h00;
        case (id_q)
            8'hA5:   lut_key = 8'h3C;
            8'h5A:   lut_key = 8'hC3;
            8'hFF:   lut_key = 8'h69;
            default: lut_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (pick_vld) state_nx = S_CHECK;
            end
            S_CHECK: begin
                state_nx = (req_sel && lut_ok) ? S_GRANT : S_IDLE;
            end
            S_GRANT: begin
                if (tenure_end) state_nx = S_GAP;
            end
            S_GAP: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            granted_idx <= '0;
            id_q        <= '0;
            key_q       <= '0;
            timer       <= '0;
            reject      <= '0;
        end else begin
            reject <= '0;
            unique case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        granted_idx <= pick_idx;
                        id_q        <= dev_id[{pick_idx, 3'b000} +: 8];
                    end
                end
                S_CHECK: begin
                    if (req_sel) begin
                        if (lut_ok) begin
                            key_q <= lut_key;
                            timer <= 8'(GRANT_CYCLES);
                        end else begin
                            reject[granted_idx] <= 1'b1;
                            rr_ptr              <= nxt_idx;
                        end
                    end
                end
                S_GRANT: begin
                    if (tenure_end) begin
                        rr_ptr <= nxt_idx;
                    end else begin
                        timer <= timer - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant    = '0;
        bus_key  = 8'h00;
        bus_busy = 1'b0;
        unique case (state)
            S_CHECK: begin
                bus_busy = 1'b1;
            end
            S_GRANT: begin
                bus_busy           = 1'b1;
                grant[granted_idx] = 1'b1;
                bus_key            = key_q;
            end
            default: ;
        endcase
    end

    assign bus_grant = |grant;

`ifdef AUDIO_ARB_LOCKOUT_EN
    logic [1:0] rej_cnt [NUM_REQ];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rej_cnt[i] <= 2'd0;
            end
        end else if (state == S_CHECK && req_sel) begin
            if (lut_ok) begin
                rej_cnt[granted_idx] <= 2'd0;
            end else if (rej_cnt[granted_idx] != 2'd3) begin
                rej_cnt[granted_idx] <= rej_cnt[granted_idx] + 2'd1;
            end
        end
    end

    always_comb begin
        locked = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            locked[i] = (rej_cnt[i] == 2'd3);
        end
    end
`else
    assign locked = '0;
`endif

endmodule
